// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared widths, psum tag codes and FSM encodings for psum_accum
`ifndef BIT_PSUM
`define BIT_PSUM 16
`endif
`ifndef BIT_VALID
`define BIT_VALID 2
`endif

package psum_accum_pkg;
    localparam int PSUM_W    = `BIT_PSUM;
    localparam int VALID_W   = `BIT_VALID;
    localparam int ACC_W_DEF = `BIT_PSUM + 4;
    localparam logic [1:0] VTAG_NONE  = 2'd0;
    localparam logic [1:0] VTAG_FIRST = 2'd1;
    localparam logic [1:0] VTAG_ACC   = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
endpackage

// File: rtl/psum_buf_ram.sv
// psum_buf_ram: simple dual-port accumulator buffer, one write and one registered read per cycle
module psum_buf_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 20
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // write port plus read with one cycle of latency (read returns pre-write data)
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/psum_accum.sv
// psum_accum: column-bottom psum accumulator with drain/clear; `define ACC_SAT_EN for saturating adds
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [PSUM_W-1:0]  Psum_In,
    input  logic [ADDR_W-1:0]  Addr_P_In,
    input  logic [VALID_W-1:0] Valid_P_In,
    input  logic               Drain_Start,
    output logic [ACC_W-1:0]   Out_Data,
    output logic [ADDR_W-1:0]  Out_Addr,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic               Busy,
    output logic               Done,
    output logic               Err
);
    logic [1:0]        r_state;
    logic [1:0]        r_s1_tag, r_s2_tag;
    logic [ADDR_W-1:0] r_s1_addr, r_s2_addr;
    logic [PSUM_W-1:0] r_s1_psum, r_s2_psum;
    logic              r_s2_fwd;
    logic [ACC_W-1:0]  r_s2_fwd_data;
    logic              r_pend, r_done, r_err;
    logic [ADDR_W-1:0] r_clr_ptr, r_rd_ptr, r_inf_addr;
    logic              r_rd_end, r_inf;
    logic              r_out_vld, r_skid_vld;
    logic [ACC_W-1:0]  r_out_data, r_skid_data;
    logic [ADDR_W-1:0] r_out_addr, r_skid_addr;

    logic              w_busy, w_in_vld, w_go, w_fwd;
    logic [1:0]        w_in_tag;
    logic [ACC_W-1:0]  w_rdata, w_ext, w_base, w_add, w_acc_res, w_s2_sum;
    logic              w_hs, w_adv, w_skid_nxt, w_issue, w_last, w_clr_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [ACC_W-1:0]  w_wdata;

    assign w_busy     = r_state != ST_IDLE;
    assign w_in_tag   = Valid_P_In[1:0];
    assign w_in_vld   = w_in_tag != VTAG_NONE;
    assign w_go       = !w_busy && (Drain_Start || r_pend) && !w_in_vld
                        && r_s1_tag == VTAG_NONE && r_s2_tag == VTAG_NONE;
    assign w_ext      = {{(ACC_W-PSUM_W){r_s2_psum[PSUM_W-1]}}, r_s2_psum};
    assign w_base     = r_s2_fwd ? r_s2_fwd_data : w_rdata;
    assign w_add      = w_base + w_ext;
`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign w_acc_res  = (w_base[ACC_W-1] == w_ext[ACC_W-1] && w_add[ACC_W-1] != w_base[ACC_W-1])
                        ? (w_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_add;
`else
    assign w_acc_res  = w_add;
`endif
    assign w_s2_sum   = r_s2_tag == VTAG_FIRST ? w_ext : w_acc_res;
    // S1's read misses the write S2 is performing this cycle, so carry S2's sum forward
    assign w_fwd      = r_s2_tag != VTAG_NONE && r_s2_addr == r_s1_addr;
    assign w_hs       = r_out_vld && Out_Ready;
    assign w_adv      = w_hs || !r_out_vld;
    assign w_skid_nxt = w_adv ? (r_skid_vld && r_inf) : (r_skid_vld || r_inf);
    // only read when the skid will be free to catch the returning word
    assign w_issue    = r_state == ST_DRAIN && !r_rd_end && !w_skid_nxt;
    assign w_last     = w_hs && r_out_addr == ADDR_W'(DEPTH-1);
    assign w_clr_last = r_clr_ptr == ADDR_W'(DEPTH-1);
    assign w_we       = r_state == ST_CLEAR || r_s2_tag != VTAG_NONE;
    assign w_waddr    = r_state == ST_CLEAR ? r_clr_ptr : r_s2_addr;
    assign w_wdata    = r_state == ST_CLEAR ? '0 : w_s2_sum;
    assign w_raddr    = r_state == ST_DRAIN ? r_rd_ptr : r_s1_addr;

    psum_buf_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(ACC_W)) u_ram (
        .i_clk(CLK), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
        .i_raddr(w_raddr), .o_rdata(w_rdata)
    );

    // two-stage accumulate pipeline; psums arriving while busy are dropped
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_tag <= VTAG_NONE;
            r_s2_tag <= VTAG_NONE;
            r_s2_fwd <= 1'b0;
        end else begin
            r_s1_tag      <= w_busy ? VTAG_NONE : w_in_tag;
            r_s1_addr     <= Addr_P_In;
            r_s1_psum     <= Psum_In;
            r_s2_tag      <= r_s1_tag;
            r_s2_addr     <= r_s1_addr;
            r_s2_psum     <= r_s1_psum;
            r_s2_fwd      <= w_fwd;
            r_s2_fwd_data <= w_s2_sum;
        end
    end

    // IDLE/DRAIN/CLEAR sequencing, pending drain request, done pulse and sticky error
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clr_ptr <= '0;
        end else begin
            r_done    <= r_state == ST_CLEAR && w_clr_last;
            r_err     <= r_err || (w_busy && (w_in_vld || Drain_Start));
            r_pend    <= !w_busy && !w_go && (r_pend || Drain_Start);
            r_clr_ptr <= r_state == ST_CLEAR ? r_clr_ptr + 1'b1 : '0;
            r_state   <= w_go ? ST_DRAIN :
                         w_last ? ST_CLEAR :
                         (r_state == ST_CLEAR && w_clr_last) ? ST_IDLE : r_state;
        end
    end

    // drain read issue and output register with one-entry skid
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_skid_vld <= 1'b0;
            r_inf      <= 1'b0;
            r_rd_ptr   <= '0;
            r_rd_end   <= 1'b0;
        end else begin
            r_inf      <= w_issue;
            r_inf_addr <= r_rd_ptr;
            r_rd_ptr   <= w_go ? '0 : w_issue ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_rd_end   <= !w_go && (r_rd_end || (w_issue && r_rd_ptr == ADDR_W'(DEPTH-1)));
            r_skid_vld <= w_skid_nxt;
            if (w_adv) r_out_vld <= r_skid_vld || r_inf;
            if (w_adv && (r_skid_vld || r_inf)) begin
                r_out_data <= r_skid_vld ? r_skid_data : w_rdata;
                r_out_addr <= r_skid_vld ? r_skid_addr : r_inf_addr;
            end
            if (r_inf && !(w_adv && !r_skid_vld)) begin
                r_skid_data <= w_rdata;
                r_skid_addr <= r_inf_addr;
            end
        end
    end

    assign Out_Data  = r_out_data;
    assign Out_Addr  = r_out_addr;
    assign Out_Valid = r_out_vld;
    assign Busy      = w_busy;
    assign Done      = r_done;
    assign Err       = r_err;
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed stimulus with a scoreboard queue checked by an output monitor
module tb_psum_accum;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int ACC_W  = 20;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [15:0]       Psum_In = '0;
    logic [ADDR_W-1:0] Addr_P_In = '0;
    logic [1:0]        Valid_P_In = '0;
    logic              Drain_Start = 1'b0;
    logic              Out_Ready = 1'b0;
    logic [ACC_W-1:0]  Out_Data;
    logic [ADDR_W-1:0] Out_Addr;
    logic              Out_Valid, Busy, Done, Err;

    psum_accum #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .Psum_In(Psum_In), .Addr_P_In(Addr_P_In),
        .Valid_P_In(Valid_P_In), .Drain_Start(Drain_Start), .Out_Data(Out_Data),
        .Out_Addr(Out_Addr), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_hs = 0;
    logic [ADDR_W+ACC_W-1:0] q[$];
    logic [ACC_W-1:0] exp_buf [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // monitor: every presented beat must match the queue head; pop on handshake
    always @(negedge CLK) begin
        if (RST_N) begin
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (Out_Valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_beat: got addr %0d data %h, expected no beat", Out_Addr, Out_Data);
                end else begin
                    chk("beat", {3'b0, Out_Addr, Out_Data}, {3'b0, q[0]});
                    if (Out_Ready) begin
                        if (Out_Addr == ADDR_W'(DEPTH-1)) last_hs = cyc;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [1:0] tag, input int addr, input int val);
        Valid_P_In = tag;
        Addr_P_In  = addr[ADDR_W-1:0];
        Psum_In    = val[15:0];
        tick();
        Valid_P_In = '0;
    endtask

    task automatic clr_exp;
        for (int i = 0; i < DEPTH; i++) exp_buf[i] = '0;
    endtask

    task automatic push_all;
        for (int i = 0; i < DEPTH; i++) q.push_back({i[ADDR_W-1:0], exp_buf[i]});
    endtask

    task automatic start_drain;
        Drain_Start = 1'b1;
        tick();
        Drain_Start = 1'b0;
    endtask

    task automatic wait_busy;
        for (int i = 0; i < 10 && !Busy; i++) tick();
        chk("busy_rise", Busy, 1);
    endtask

    task automatic finish_drain(input int mode);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            Out_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 4 == 0 || i % 4 == 3) : 1'($urandom_range(0, 1));
            tick();
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("all_beats", q.size(), 0);
        chk("busy_after_done", Busy, 0);
        Out_Ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_out_data", Out_Data, 0);
        chk("rst_out_addr", Out_Addr, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        RST_N = 1'b1;
        tick();
        // every entry FIRST-written with its own address, full-rate drain
        for (int a = 0; a < DEPTH; a++) begin
            put(2'd1, a, a);
            exp_buf[a] = ACC_W'(a);
        end
        push_all();
        start_drain();
        finish_drain(0);
        chk("done_latency", done_cyc - last_hs, DEPTH + 1);
        // CLEAR must have zeroed every entry
        clr_exp();
        push_all();
        start_drain();
        finish_drain(0);
        // forwarding at distances 1..3, interleaving, FIRST override, drain right after an ACC
        clr_exp();
        put(2'd1, 3, 5); put(2'd2, 3, -2); put(2'd2, 3, 7);
        put(2'd1, 4, 100); tick(); put(2'd2, 4, 1); tick(); tick(); put(2'd2, 4, 1);
        put(2'd3, 5, -7);
        put(2'd1, 6, 1); put(2'd1, 7, 2); put(2'd2, 6, 10); put(2'd2, 7, 20);
        put(2'd1, 9, 50); put(2'd2, 9, 5); put(2'd1, 9, 3);
        put(2'd2, 8, 9);
        exp_buf[3] = 20'd10;
        exp_buf[4] = 20'd102;
        exp_buf[5] = 20'hFFFF9;
        exp_buf[6] = 20'd11;
        exp_buf[7] = 20'd22;
        exp_buf[8] = 20'd9;
        exp_buf[9] = 20'd3;
        push_all();
        start_drain();
        chk("drain_pending_busy", Busy, 0);
        finish_drain(1);
        // psums during DRAIN are dropped and flag Err
        clr_exp();
        put(2'd1, 0, 42);
        exp_buf[0] = 20'd42;
        push_all();
        start_drain();
        wait_busy();
        chk("err_before", Err, 0);
        put(2'd1, 0, 77);
        put(2'd2, 10, 5);
        chk("err_psum_busy", Err, 1);
        finish_drain(2);
        // overflow at both ends of the accumulator range
        clr_exp();
        put(2'd1, 1, 32767);
        repeat (15) put(2'd2, 1, 32767);
        put(2'd2, 1, 15);
        put(2'd2, 1, 1);
        put(2'd1, 2, -32768);
        repeat (15) put(2'd2, 2, -32768);
        put(2'd2, 2, -1);
`ifdef ACC_SAT_EN
        exp_buf[1] = 20'h7FFFF;
        exp_buf[2] = 20'h80000;
`else
        exp_buf[1] = 20'h80000;
        exp_buf[2] = 20'h7FFFF;
`endif
        push_all();
        start_drain();
        finish_drain(2);
        chk("err_sticky", Err, 1);
        // reset, Drain_Start while busy, then reset mid-drain
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("err_cleared", Err, 0);
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            put(2'd1, a, DEPTH - 1 - a);
            exp_buf[a] = ACC_W'(DEPTH - 1 - a);
        end
        push_all();
        Out_Ready = 1'b1;
        start_drain();
        wait_busy();
        Drain_Start = 1'b1;
        tick();
        Drain_Start = 1'b0;
        chk("err_drain_busy", Err, 1);
        repeat (20) tick();
        chk("mid_drain_valid", Out_Valid, 1);
        RST_N = 1'b0;
        tick();
        chk("rst_mid_valid", Out_Valid, 0);
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_done", Done, 0);
        chk("rst_mid_err", Err, 0);
        q.delete();
        RST_N = 1'b1;
        Out_Ready = 1'b0;
        tick();
        tick();
        chk("post_rst_valid", Out_Valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
